// File: rtl/demux_1a2.sv
// demux_1a2: splits one BW-bit stream into two lanes, each with a 2-entry FIFO.
// Optional macro DEMUX_EXT_SEL_EN replaces the internal alternating select with an external `selector` port.
module demux_1a2 #(
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          reset_L,
`ifdef DEMUX_EXT_SEL_EN
  input  logic          selector,
`endif
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  output logic          ready_in,
  output logic [BW-1:0] data_out0,
  output logic          valid_out0,
  input  logic          ready_out0,
  output logic [BW-1:0] data_out1,
  output logic          valid_out1,
  input  logic          ready_out1
);

  logic [BW-1:0] r_head [2];
  logic [BW-1:0] r_tail [2];
  logic [1:0]    r_cnt  [2];

  logic [BW-1:0] w_head_nxt [2];
  logic [BW-1:0] w_tail_nxt [2];
  logic [1:0]    w_cnt_nxt  [2];

  logic          w_sel;
  logic          w_accept;
  logic [1:0]    w_valid;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_ready_out;
  logic [1:0]    w_sel_cnt;

`ifdef DEMUX_EXT_SEL_EN
  assign w_sel = selector;
`else
  logic r_sel;

  // Alternating lane select: toggles only when a word is actually taken.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_sel <= 1'b0;
    end else if (w_accept) begin
      r_sel <= ~r_sel;
    end else begin
      r_sel <= r_sel;
    end
  end

  assign w_sel = r_sel;
`endif

  // The selected lane must have room; a pop on that same lane does not count (no pass-through).
  assign w_sel_cnt   = w_sel ? r_cnt[1] : r_cnt[0];
  assign ready_in    = reset_L & (w_sel_cnt < 2'd2);
  assign w_accept    = valid_in & ready_in;

  assign w_valid     = {(r_cnt[1] != 2'd0), (r_cnt[0] != 2'd0)};
  assign w_ready_out = {ready_out1, ready_out0};
  assign w_push      = {w_accept & w_sel, w_accept & ~w_sel};
  assign w_pop       = w_valid & w_ready_out;

  // Per-lane FIFO next state; head is always entry 0, emptied slots read back as zero.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_head_nxt[n] = r_head[n];
      w_tail_nxt[n] = r_tail[n];
      w_cnt_nxt[n]  = r_cnt[n];
      case ({w_push[n], w_pop[n]})
        2'b10: begin
          if (r_cnt[n] == 2'd0) begin
            w_head_nxt[n] = data_in;
          end else begin
            w_tail_nxt[n] = data_in;
          end
          w_cnt_nxt[n] = r_cnt[n] + 2'd1;
        end
        2'b01: begin
          w_head_nxt[n] = r_tail[n];
          w_tail_nxt[n] = {BW{1'b0}};
          w_cnt_nxt[n]  = r_cnt[n] - 2'd1;
        end
        2'b11: begin
          if (r_cnt[n] == 2'd1) begin
            w_head_nxt[n] = data_in;
          end else begin
            w_head_nxt[n] = r_tail[n];
            w_tail_nxt[n] = data_in;
          end
        end
        default: begin
          w_cnt_nxt[n] = r_cnt[n];
        end
      endcase
    end
  end

  // Lane buffer registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      for (int n = 0; n < 2; n++) begin
        r_head[n] <= {BW{1'b0}};
        r_tail[n] <= {BW{1'b0}};
        r_cnt[n]  <= 2'd0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        r_head[n] <= w_head_nxt[n];
        r_tail[n] <= w_tail_nxt[n];
        r_cnt[n]  <= w_cnt_nxt[n];
      end
    end
  end

  assign data_out0  = r_head[0];
  assign data_out1  = r_head[1];
  assign valid_out0 = w_valid[0];
  assign valid_out1 = w_valid[1];

endmodule
